mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//  MEM-stage load/store controller sitting directly upstream of Dmemory. Accepts one load/store
//  request from the CPU pipeline, checks alignment, drives Dmemory's start/wea/addr/in_data/rol,
//  waits out its multi-cycle busy, then sign/zero-extends load data and releases the pipeline stall.
// PARAMETERS
//  WAIT_MAX   64   max cycles in WAIT before timeout error (>=4)
// PORTS
//  clk          in   1   clock; all state on posedge clk
//  rst          in   1   synchronous, active-high reset
//  req          in   1   CPU load/store request, held high until done
//  op           in   3   access type (see package encoding)
//  addr         in   32  byte address
//  wdata        in   32  store data, right-aligned
//  stall        out  1   freeze pipeline; high while request is outstanding
//  done         out  1   1-cycle pulse: access finished (or rejected)
//  err          out  1   1-cycle pulse with done: misaligned or timeout
//  rdata        out  32  extended load data, valid on done, held until next done
//  dm_start     out  1   Dmemory start, 1-cycle pulse
//  dm_wea       out  1   Dmemory write enable, held for whole access
//  dm_addr      out  32  Dmemory address, held for whole access
//  dm_wdata     out  32  Dmemory in_data, held for whole access
//  dm_rol       out  3   Dmemory byte count: 3'd1 byte, 3'd2 half, 3'd4 word
//  dm_busy      in   1   Dmemory busy
//  dm_rdata     in   32  Dmemory out_data, right-aligned, valid when busy falls
// BEHAVIOUR
//  Reset: state=IDLE; stall,done,err,dm_start,dm_wea=0; rdata,dm_addr,dm_wdata=0; dm_rol=3'd4.
//  States: IDLE -> ISSUE -> ARM -> WAIT -> DONE -> IDLE.
//  IDLE: on req=1: misaligned (half with addr[0]=1, word with addr[1:0]!=0) -> DONE with err;
//        else latch addr/wdata/op into dm_* regs, -> ISSUE. stall = req (combinational) in IDLE.
//  ISSUE: dm_start=1 exactly this cycle -> ARM.
//  ARM: one cycle, dm_busy ignored (Dmemory raises busy one cycle after start) -> WAIT.
//  WAIT: stay while dm_busy=1; on dm_busy=0 -> DONE, capturing dm_rdata; wait counter reaching
//        WAIT_MAX -> DONE with err, rdata=0.
//  DONE: done=1 one cycle, stall=0 in this cycle so pipeline advances; -> IDLE. A req seen in
//        IDLE the next cycle is a new request (CPU must drop/replace req on done).
//  stall=1 in ISSUE/ARM/WAIT; 0 in DONE.
//  Load extension: LB sign-ext bit7, LBU zero-ext [7:0], LH sign-ext bit15, LHU zero-ext [15:0],
//   LW as-is. Stores: rdata unchanged. Stores: dm_wdata masked to byte/half (upper bits 0).
//  dm_wea=1 only for SB/SH/SW; loads drive dm_wdata=0.
//  Error path issues no dm_start; Dmemory untouched.
//  rst mid-access: immediate IDLE, all outputs to reset values next edge; Dmemory shares rst so
//   no orphaned transfer. dm_busy high while in IDLE is ignored.
//  Total load/store latency, aligned: req-accept edge + ISSUE + ARM + N busy cycles + DONE.
// STRUCTURE
//  Package mem_pkg: op encoding LB=0 LBU=1 LH=2 LHU=3 LW=4 SB=5 SH=6 SW=7; ROL_B/ROL_H/ROL_W
//   constants; state enum; function is_store(op).
//  One sub-module: load_extend (combinational op + dm_rdata -> extended 32-bit). FSM in top.
// TESTING
//  LB addr=0x10, dm_rdata=0x0000_0080 -> rdata=0xFFFF_FF80, dm_rol=1, dm_wea=0, one dm_start.
//  LHU addr=0x12, dm_rdata=0x0000_8001 -> rdata=0x0000_8001, err=0, dm_rol=2.
//  SW addr=0x20 wdata=0xDEAD_BEEF, busy 4 cycles -> dm_wea=1, dm_addr=0x20, done 1 cycle after
//   busy falls, stall low only in DONE.
//  LW addr=0x21 -> done+err next cycle after accept, no dm_start, rdata unchanged.
//  LW with busy stuck high -> err+done after WAIT_MAX cycles in WAIT, rdata=0.
//  rst asserted during WAIT of SH -> next cycle IDLE, stall=0, dm_start=0, dm_wea=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage load/store controller: op codes, Dmemory
// byte counts, FSM state constants and small decode helpers.
package mem_pkg;

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LBU = 3'd1;
  localparam logic [2:0] OP_LH  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LW  = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  localparam logic [2:0] ROL_B = 3'd1;
  localparam logic [2:0] ROL_H = 3'd2;
  localparam logic [2:0] ROL_W = 3'd4;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_ISSUE = 3'd1;
  localparam state_t ST_ARM   = 3'd2;
  localparam state_t ST_WAIT  = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  function automatic logic is_store(input logic [2:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [2:0] op_rol(input logic [2:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return ROL_B;
      OP_LH, OP_LHU, OP_SH: return ROL_H;
      default:              return ROL_W;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
    case (op_rol(op))
      ROL_H:   return a[0];
      ROL_W:   return (a != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  // Loads put nothing on the write bus; narrow stores clear the unused upper bits.
  function automatic logic [31:0] store_data(input logic [2:0] op, input logic [31:0] wd);
    case (op)
      OP_SB:   return {24'h00_0000, wd[7:0]};
      OP_SH:   return {16'h0000, wd[15:0]};
      OP_SW:   return wd;
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_extend.sv
// Combinational sign/zero extension of right-aligned Dmemory read data.
module load_extend
  import mem_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] dm_rdata,
  output logic [31:0] ext
);

  always_comb begin
    case (op)
      OP_LB:   ext = {{24{dm_rdata[7]}}, dm_rdata[7:0]};
      OP_LBU:  ext = {24'h00_0000, dm_rdata[7:0]};
      OP_LH:   ext = {{16{dm_rdata[15]}}, dm_rdata[15:0]};
      OP_LHU:  ext = {16'h0000, dm_rdata[15:0]};
      default: ext = dm_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: alignment check, Dmemory handshake,
// busy wait with timeout, load extension and pipeline stall control.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int WAIT_MAX = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        dm_start,
  output logic        dm_wea,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [2:0]  dm_rol,
  input  logic        dm_busy,
  input  logic [31:0] dm_rdata
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic               err_q, err_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               dm_wea_q, dm_wea_d;
  logic [31:0]        dm_addr_q, dm_addr_d;
  logic [31:0]        dm_wdata_q, dm_wdata_d;
  logic [2:0]         dm_rol_q, dm_rol_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        ext_s;

  load_extend u_load_extend (
    .op       (op_q),
    .dm_rdata (dm_rdata),
    .ext      (ext_s)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    dm_wea_d   = dm_wea_q;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    dm_rol_d   = dm_rol_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          // A rejected access never touches the Dmemory-facing registers.
          if (misaligned(op, addr[1:0])) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else begin
            state_d    = ST_ISSUE;
            op_d       = op;
            dm_wea_d   = is_store(op);
            dm_addr_d  = addr;
            dm_wdata_d = store_data(op, wdata);
            dm_rol_d   = op_rol(op);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: state_d = ST_ARM;
      ST_ARM: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        if (!dm_busy) begin
          state_d = ST_DONE;
          if (!is_store(op_q)) begin
            rdata_d = ext_s;
          end else begin
            rdata_d = rdata_q;
          end
        end else if (cnt_q == CNT_W'(WAIT_MAX - 1)) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
          rdata_d = 32'h0000_0000;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        err_d    = 1'b0;
        dm_wea_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_LW;
      err_q      <= 1'b0;
      rdata_q    <= 32'h0000_0000;
      dm_wea_q   <= 1'b0;
      dm_addr_q  <= 32'h0000_0000;
      dm_wdata_q <= 32'h0000_0000;
      dm_rol_q   <= ROL_W;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      dm_wea_q   <= dm_wea_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      dm_rol_q   <= dm_rol_d;
      cnt_q      <= cnt_d;
    end
  end

  // In IDLE the stall follows req so the pipeline freezes in the accept cycle.
  assign stall    = (state_q == ST_IDLE) ? req : (state_q != ST_DONE);
  assign done     = (state_q == ST_DONE);
  assign err      = err_q;
  assign rdata    = rdata_q;
  assign dm_start = (state_q == ST_ISSUE);
  assign dm_wea   = dm_wea_q;
  assign dm_addr  = dm_addr_q;
  assign dm_wdata = dm_wdata_q;
  assign dm_rol   = dm_rol_q;

endmodule
